// File: rtl/move_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module   : move_entry_pkg
// Purpose  : Shared game definitions for the move-entry keypad front end:
//            key-code constants, entry FSM state encodings and small
//            digit-decoding helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package move_entry_pkg;

   typedef logic [3:0] key_code_t;

   // Command keys on the hex keypad
   localparam key_code_t KEY_A = 4'hA;   // board chosen, move on to cell
   localparam key_code_t KEY_C = 4'hC;   // cancel partial entry
   localparam key_code_t KEY_E = 4'hE;   // enter / commit move

   // Entry FSM state codes, also exported on entry_state for display
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GOT_B  = 2'd1,
      ST_WAIT_C = 2'd2,
      ST_GOT_C  = 2'd3
   } entry_state_t;

   // Codes 1..9 are digits; 0 is deliberately not a digit
   function automatic logic is_digit(input key_code_t code);
      return (code >= 4'd1) && (code <= 4'd9);
   endfunction

   // Digits map to board/cell indices 0..8
   function automatic logic [3:0] digit_index(input key_code_t code);
      return code - 4'd1;
   endfunction

endpackage : move_entry_pkg
`default_nettype wire

// File: rtl/move_entry_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Stability filter for the keypad scanner's last-pressed code.
//            A new code must stay unchanged for STABLE_TICKS cycles before
//            it is accepted; acceptance of a code different from the last
//            accepted one raises a single-cycle key_evt.
// Ports    : clk     - system clock, rising edge
//            rst_n   - asynchronous active-low reset
//            key     - raw key code from the scanner
//            acc     - last accepted key code
//            key_evt - one-cycle strobe, acc has just taken a new value
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce
   import move_entry_pkg::*;
#(
   parameter int STABLE_TICKS = 2_000_000,
   parameter int CNT_BITS     = 21
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key,
   output logic [3:0] acc,
   output logic       key_evt
);

   localparam logic [CNT_BITS-1:0] c_STABLE = CNT_BITS'(STABLE_TICKS);
   localparam logic [CNT_BITS-1:0] c_ONE    = CNT_BITS'(1);

   key_code_t             r_key;
   key_code_t             r_cand;
   key_code_t             r_acc;
   logic [CNT_BITS-1:0]   r_cnt;
   logic                  r_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key  <= '0;
         r_cand <= '0;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_evt  <= 1'b0;
      end else begin
         r_key <= key;
         r_evt <= 1'b0;

         // Any change restarts the stability window; the counter saturates
         if (r_key != r_cand) begin
            r_cand <= r_key;
            r_cnt  <= '0;
         end else if (r_cnt < c_STABLE) begin
            r_cnt <= r_cnt + c_ONE;
         end

         // acc catches up with cand in the same edge, so the event cannot
         // repeat until cand moves; settling back on acc gives no event
         if ((r_cnt == c_STABLE) && (r_cand != r_acc)) begin
            r_evt <= 1'b1;
            r_acc <= r_cand;
         end
      end
   end

   assign acc     = r_acc;
   assign key_evt = r_evt;

endmodule : key_debounce
`default_nettype wire

// File: rtl/move_entry.sv
`default_nettype none
// ============================================================================
// Module   : move_entry
// Purpose  : Keypad move entry for the board game. Debounced key events
//            drive a four-state FSM: board digit, A, cell digit, E commits.
//            C cancels from any state; anything else flags key_err.
// Ports    : clk         - 100 MHz system clock, rising edge
//            rst_n       - asynchronous active-low reset
//            key         - last-pressed key code from the scanner
//            move_valid  - one-cycle strobe, a move was committed
//            move_board  - committed sub-board index 0..8 (held)
//            move_cell   - committed cell index 0..8 (held)
//            entry_state - current FSM state code
//            key_err     - one-cycle strobe, illegal key for this state
// Revision : 1.0 - initial release
// ============================================================================
module move_entry
   import move_entry_pkg::*;
#(
   parameter int STABLE_TICKS = 2_000_000,
   parameter int CNT_BITS     = 21
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] key,
   output logic       move_valid,
   output logic [3:0] move_board,
   output logic [3:0] move_cell,
   output logic [1:0] entry_state,
   output logic       key_err
);

   key_code_t    w_acc;
   logic         w_key_evt;

   entry_state_t r_state;
   logic [3:0]   r_board;
   logic [3:0]   r_cell;
   logic         r_move_valid;
   logic [3:0]   r_move_board;
   logic [3:0]   r_move_cell;
   logic         r_key_err;

   key_debounce #(
      .STABLE_TICKS (STABLE_TICKS),
      .CNT_BITS     (CNT_BITS)
   ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .key     (key),
      .acc     (w_acc),
      .key_evt (w_key_evt)
   );

   // acc already holds the new code in the cycle key_evt is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_board      <= '0;
         r_cell       <= '0;
         r_move_valid <= 1'b0;
         r_move_board <= '0;
         r_move_cell  <= '0;
         r_key_err    <= 1'b0;
      end else begin
         r_move_valid <= 1'b0;
         r_key_err    <= 1'b0;

         if (w_key_evt) begin
            if (w_acc == KEY_C) begin
               r_state <= ST_IDLE;
            end else begin
               case (r_state)
                  ST_IDLE: begin
                     if (is_digit(w_acc)) begin
                        r_board <= digit_index(w_acc);
                        r_state <= ST_GOT_B;
                     end else begin
                        r_key_err <= 1'b1;
                     end
                  end
                  ST_GOT_B: begin
                     if (is_digit(w_acc)) begin
                        r_board <= digit_index(w_acc);
                     end else if (w_acc == KEY_A) begin
                        r_state <= ST_WAIT_C;
                     end else begin
                        r_key_err <= 1'b1;
                     end
                  end
                  ST_WAIT_C: begin
                     if (is_digit(w_acc)) begin
                        r_cell  <= digit_index(w_acc);
                        r_state <= ST_GOT_C;
                     end else begin
                        r_key_err <= 1'b1;
                     end
                  end
                  ST_GOT_C: begin
                     if (is_digit(w_acc)) begin
                        r_cell <= digit_index(w_acc);
                     end else if (w_acc == KEY_E) begin
                        r_move_valid <= 1'b1;
                        r_move_board <= r_board;
                        r_move_cell  <= r_cell;
                        r_state      <= ST_IDLE;
                     end else begin
                        r_key_err <= 1'b1;
                     end
                  end
                  default: r_state <= ST_IDLE;
               endcase
            end
         end
      end
   end

   assign move_valid  = r_move_valid;
   assign move_board  = r_move_board;
   assign move_cell   = r_move_cell;
   assign entry_state = r_state;
   assign key_err     = r_key_err;

endmodule : move_entry
`default_nettype wire

// File: tb/tb_move_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_entry
// Purpose  : Self-checking bench for move_entry with a short debounce
//            window. A table of key steps with hand-computed state and
//            output expectations, plus directed debounce and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_entry;

   localparam int STABLE_TICKS = 4;
   localparam int CNT_BITS     = 3;
   localparam int HOLD         = 12;   // cycles a key is held per step
   localparam int NSTEPS       = 21;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] key;
   logic       move_valid;
   logic [3:0] move_board;
   logic [3:0] move_cell;
   logic [1:0] entry_state;
   logic       key_err;

   int n_checks = 0;
   int n_errors = 0;

   // Running event counters, sampled 1 time unit after each rising edge
   int n_evt     = 0;
   int n_mv      = 0;
   int n_err     = 0;
   int n_overlap = 0;

   typedef struct {
      logic [3:0] key;
      int         st;
      int         d_err;
      int         d_mv;
      int         mb;
      int         mc;
   } step_t;

   step_t steps [NSTEPS];

   move_entry #(
      .STABLE_TICKS (STABLE_TICKS),
      .CNT_BITS     (CNT_BITS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key         (key),
      .move_valid  (move_valid),
      .move_board  (move_board),
      .move_cell   (move_cell),
      .entry_state (entry_state),
      .key_err     (key_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (dut.w_key_evt)         n_evt++;
      if (move_valid)            n_mv++;
      if (key_err)               n_err++;
      if (move_valid && key_err) n_overlap++;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one key code at a falling edge, hold it, report event deltas
   task automatic run_step(input logic [3:0] k, input int hold,
                           output int d_evt, output int d_err, output int d_mv);
      int e0, r0, m0;
      @(negedge clk);
      e0 = n_evt; r0 = n_err; m0 = n_mv;
      key = k;
      repeat (hold) @(negedge clk);
      d_evt = n_evt - e0;
      d_err = n_err - r0;
      d_mv  = n_mv  - m0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, ".move_valid"},  int'(move_valid),  0);
      chk({tag, ".move_board"},  int'(move_board),  0);
      chk({tag, ".move_cell"},   int'(move_cell),   0);
      chk({tag, ".entry_state"}, int'(entry_state), 0);
      chk({tag, ".key_err"},     int'(key_err),     0);
   endtask

   initial begin
      int de, dr, dm, e0, r0;

      // key, state, err pulses, valid pulses, move_board, move_cell
      steps[0]  = '{4'hA, 2, 0, 0, 0, 0};
      steps[1]  = '{4'h5, 3, 0, 0, 0, 0};
      steps[2]  = '{4'hE, 0, 0, 1, 4, 4};
      steps[3]  = '{4'h3, 1, 0, 0, 4, 4};
      steps[4]  = '{4'hA, 2, 0, 0, 4, 4};
      steps[5]  = '{4'hE, 2, 1, 0, 4, 4};
      steps[6]  = '{4'h9, 3, 0, 0, 4, 4};
      steps[7]  = '{4'hE, 0, 0, 1, 2, 8};
      steps[8]  = '{4'h2, 1, 0, 0, 2, 8};
      steps[9]  = '{4'hA, 2, 0, 0, 2, 8};
      steps[10] = '{4'hC, 0, 0, 0, 2, 8};
      steps[11] = '{4'hF, 0, 1, 0, 2, 8};
      steps[12] = '{4'h0, 0, 1, 0, 2, 8};
      steps[13] = '{4'hA, 0, 1, 0, 2, 8};
      steps[14] = '{4'h1, 1, 0, 0, 2, 8};
      steps[15] = '{4'h7, 1, 0, 0, 2, 8};
      steps[16] = '{4'hE, 1, 1, 0, 2, 8};
      steps[17] = '{4'hA, 2, 0, 0, 2, 8};
      steps[18] = '{4'h8, 3, 0, 0, 2, 8};
      steps[19] = '{4'h2, 3, 0, 0, 2, 8};
      steps[20] = '{4'hE, 0, 0, 1, 6, 1};

      // Reset state
      rst_n = 1'b0;
      key   = 4'h0;
      repeat (3) @(negedge clk);
      chk_outputs_zero("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Three-cycle blip 0->7->0 must be filtered out
      e0 = n_evt; r0 = n_err;
      key = 4'h7;
      repeat (3) @(negedge clk);
      key = 4'h0;
      repeat (HOLD) @(negedge clk);
      chk("blip.key_evt", n_evt - e0, 0);
      chk("blip.key_err", n_err - r0, 0);
      chk("blip.state",   int'(entry_state), 0);

      // 0->5 held: exactly one event, none more while still held
      run_step(4'h5, HOLD, de, dr, dm);
      chk("hold5.key_evt", de, 1);
      chk("hold5.state",   int'(entry_state), 1);
      e0 = n_evt;
      repeat (HOLD) @(negedge clk);
      chk("hold5.no_repeat", n_evt - e0, 0);

      // Table of key steps
      for (int i = 0; i < NSTEPS; i++) begin
         run_step(steps[i].key, HOLD, de, dr, dm);
         chk($sformatf("step%0d.key_evt", i), de, 1);
         chk($sformatf("step%0d.state", i), int'(entry_state), steps[i].st);
         chk($sformatf("step%0d.key_err", i), dr, steps[i].d_err);
         chk($sformatf("step%0d.move_valid", i), dm, steps[i].d_mv);
         chk($sformatf("step%0d.move_board", i), int'(move_board), steps[i].mb);
         chk($sformatf("step%0d.move_cell", i), int'(move_cell), steps[i].mc);
      end

      // Reset in GOT_C discards the partial move
      run_step(4'h4, HOLD, de, dr, dm);
      run_step(4'hA, HOLD, de, dr, dm);
      run_step(4'h3, HOLD, de, dr, dm);
      chk("midrst.pre_state", int'(entry_state), 3);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      key   = 4'h0;
      #1;
      chk_outputs_zero("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      e0 = n_evt;
      repeat (HOLD) @(negedge clk);
      chk("midrst.held0_evt", n_evt - e0, 0);
      chk("midrst.post_state", int'(entry_state), 0);
      run_step(4'hE, HOLD, de, dr, dm);
      chk("midrst.E.move_valid", dm, 0);
      chk("midrst.E.key_err",    dr, 1);
      chk("midrst.E.state",      int'(entry_state), 0);

      chk("valid_err_overlap", n_overlap, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_move_entry
`default_nettype wire

// File: doc/move_entry.md
MOVE_ENTRY -- requirements
Module: move_entry

Interface
REQ-001 SHALL have parameter STABLE_TICKS, default 2_000_000, meaning the cycles a new key code must hold before acceptance (20 ms at 100 MHz).
REQ-002 SHALL have parameter CNT_BITS, default 21, meaning the stability counter width; it SHALL satisfy 2^CNT_BITS > STABLE_TICKS.
REQ-003 SHALL have port clk, input, 1 bit: the single 100 MHz clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port key, input, 4 bits: the last-pressed key code from the keypad scanner, on the clk domain (0-9 digits, A-F letters).
REQ-006 SHALL have port move_valid, output, 1 bit: one-cycle strobe that a move is committed.
REQ-007 SHALL have port move_board, output, 4 bits: committed sub-board index 0-8.
REQ-008 SHALL have port move_cell, output, 4 bits: committed cell index 0-8.
REQ-009 SHALL have port entry_state, output, 2 bits: current FSM state code, for display.
REQ-010 SHALL have port key_err, output, 1 bit: one-cycle strobe for an illegal key in the current state.

Function
REQ-011 SHALL register key into key_r each cycle; a candidate register cand and a counter cnt SHALL track stability.
REQ-012 SHALL, when key_r != cand, load cand <= key_r and clear cnt to 0.
REQ-013 SHALL, when key_r == cand and cnt < STABLE_TICKS, increment cnt; at no time SHALL cnt wrap.
REQ-014 SHALL raise an internal one-cycle key_evt when cnt reaches STABLE_TICKS and cand != acc, and SHALL then load acc <= cand; no further event occurs until cand changes.
REQ-015 SHALL ignore any glitch shorter than STABLE_TICKS cycles; a return to the prior acc value SHALL produce no event.
REQ-016 SHALL treat codes 1-9 as digits, stored as code-1 (range 0-8); code 0 SHALL be illegal.
REQ-017 SHALL implement FSM states IDLE=0, GOT_B=1, WAIT_C=2, GOT_C=3, driven only on key_evt.
REQ-018 SHALL, in IDLE, on a digit capture board_r and go to GOT_B.
REQ-019 SHALL, in GOT_B, on a digit overwrite board_r; on A go to WAIT_C.
REQ-020 SHALL, in WAIT_C, on a digit capture cell_r and go to GOT_C.
REQ-021 SHALL, in GOT_C, on a digit overwrite cell_r; on E pulse move_valid, drive move_board=board_r and move_cell=cell_r, and return to IDLE.
REQ-022 SHALL, in any state, on C (cancel) go to IDLE without pulsing key_err.
REQ-023 SHALL, on any other key_evt, pulse key_err for one cycle and leave state and registers unchanged.
REQ-024 SHALL assert move_valid on the cycle after the E key_evt; move_board and move_cell SHALL hold until the next commit.
REQ-025 SHALL never assert move_valid and key_err in the same cycle.

Reset
REQ-026 SHALL, on rst_n low, immediately set state=IDLE, key_r=cand=acc=0, cnt=0, board_r=cell_r=0, and all outputs to 0.
REQ-027 SHALL, when reset is asserted mid-entry, discard the partial move; after release, a key already held at 0 SHALL produce no event.

Structure
REQ-028 SHALL place the key-code constants (KEY_A=4'hA, KEY_C=4'hC, KEY_E=4'hE) and the state encodings in the shared game package.
REQ-029 SHALL implement REQ-011 through REQ-015 in one sub-module, key_debounce (ports clk, rst_n, key, acc, key_evt), instantiated once.

Verification
REQ-030 SHALL cover: with STABLE_TICKS=4, key 0->5 held -> key_evt exactly once, and no second event while held.
REQ-031 SHALL cover: a 3-cycle blip 0->7->0 -> no key_evt and key_err=0.
REQ-032 SHALL cover: sequence 5,A,5,E -> one move_valid with move_board=4, move_cell=4, and entry_state back to 0.
REQ-033 SHALL cover: sequence 3,A,E -> key_err pulse on E, state stays WAIT_C; then 9,E -> move_board=2, move_cell=8.
REQ-034 SHALL cover: sequence 2,A,C,F -> entry_state=0 after C, key_err on F, and no move_valid.
REQ-035 SHALL cover: rst_n pulsed low in GOT_C -> all outputs 0 immediately, and the following E produces no move_valid.
